// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: branch facility, instruction memory and identify signals of the fetch stage
interface instr_fetch_unit_if;
  logic [0:63] i_nia;
  logic        o_stall;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [0:63] o_mem_addr;
  logic        i_mem_rsp_valid;
  logic [0:31] i_mem_rsp_data;
  logic        i_mem_rsp_err;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [0:31] o_instr;
  logic [0:63] o_instr_addr;
  logic        o_err_misaligned;
  logic        o_err_fetch;
  modport master (
    input  i_nia, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err, i_instr_ready,
    output o_stall, o_mem_req_valid, o_mem_addr, o_instr_valid, o_instr, o_instr_addr,
           o_err_misaligned, o_err_fetch
  );
  modport slave (
    output i_nia, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err, i_instr_ready,
    input  o_stall, o_mem_req_valid, o_mem_addr, o_instr_valid, o_instr, o_instr_addr,
           o_err_misaligned, o_err_fetch
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: non-speculative single-outstanding fetch with retry, timeout and sticky errors
module instr_fetch_unit #(
  parameter int MAX_WAIT  = 16,
  parameter int MAX_RETRY = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, PRESENT, ERROR} state_t;
  state_t      state_q, state_d;
  logic        issue_q, issue_d;
  logic [0:63] addr_q, addr_d;
  logic [0:31] instr_q, instr_d;
  logic [0:63] iaddr_q, iaddr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        mis_q, mis_d;
  logic        fet_q, fet_d;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= BOOT;
      issue_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      iaddr_q <= '0;
      wait_q  <= '0;
      retry_q <= '0;
      mis_q   <= 1'b0;
      fet_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      mis_q   <= mis_d;
      fet_q   <= fet_d;
    end
  // issue_q separates the address-sampling REQ cycle from the request cycles; retries keep it set
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    iaddr_d = iaddr_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    mis_d   = mis_q;
    fet_d   = fet_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ:
        if (!issue_q) begin
          addr_d = bus.i_nia;
          if (|bus.i_nia[62:63]) begin
            state_d = ERROR;
            mis_d   = 1'b1;
          end else issue_d = 1'b1;
        end else if (bus.i_mem_req_ready) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      WAIT: begin
        wait_d = wait_q + WW'(1);
        if (bus.i_mem_rsp_valid && !bus.i_mem_rsp_err) begin
          instr_d = bus.i_mem_rsp_data;
          iaddr_d = addr_q;
          retry_d = '0;
          issue_d = 1'b0;
          state_d = PRESENT;
        end else if (bus.i_mem_rsp_valid || wait_q == WW'(MAX_WAIT - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = REQ;
          end else begin
            state_d = ERROR;
            fet_d   = 1'b1;
          end
        end
      end
      PRESENT: state_d = bus.i_instr_ready ? REQ : PRESENT;
      default: ;
    endcase
  end
  assign bus.o_stall          = !(state_q == PRESENT && bus.i_instr_ready);
  assign bus.o_mem_req_valid  = state_q == REQ && issue_q;
  assign bus.o_mem_addr       = addr_q;
  assign bus.o_instr_valid    = state_q == PRESENT;
  assign bus.o_instr          = instr_q;
  assign bus.o_instr_addr     = iaddr_q;
  assign bus.o_err_misaligned = mis_q;
  assign bus.o_err_fetch      = fet_q;
endmodule
